// File: rtl/gbemac_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one TX AXI-stream among N_PORTS sources.
// Oversized packets are truncated with a forced tlast and their tail is drained.
module gbemac_tx_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_W     = 32,
  parameter int MAX_WORDS  = 384,
  parameter int GAP_CYCLES = 0,
  localparam int GW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int WC_W = $clog2(MAX_WORDS + 1),
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic                       Clk_user,
  input  logic                       Reset_n,
  input  logic [N_PORTS-1:0]         s_axis_tvalid,
  output logic [N_PORTS-1:0]         s_axis_tready,
  input  logic [N_PORTS*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_PORTS-1:0]         s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic                       pkt_done,
  output logic                       trunc
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DRAIN, S_GAP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant_id;
  logic [WC_W-1:0]   r_word_cnt;
  logic [GC_W-1:0]   r_gap_cnt;
  logic              r_busy;
  logic              r_pkt_done;
  logic              r_trunc;

  logic              w_req_found;
  logic [GW-1:0]     w_pick;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_at_max;
  logic              w_xfer;
  logic              w_pkt_end;
  logic [GW-1:0]     w_next_ptr;
  state_t            w_after_pkt;

  assign w_sel_valid = s_axis_tvalid[r_grant_id];
  assign w_sel_last  = s_axis_tlast[r_grant_id];
  assign w_sel_data  = s_axis_tdata[int'(r_grant_id)*DATA_W +: DATA_W];
  assign w_at_max    = (r_word_cnt == WC_W'(MAX_WORDS - 1));
  assign w_pkt_end   = w_xfer & (w_sel_last | w_at_max);
  assign w_next_ptr  = (r_grant_id == GW'(N_PORTS - 1)) ? {GW{1'b0}} : r_grant_id + {{(GW-1){1'b0}}, 1'b1};
  assign w_after_pkt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  // Scan descending so the requester closest to rr_ptr (upward, wrapping) wins.
  always_comb begin
    w_req_found = 1'b0;
    w_pick      = r_rr_ptr;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (s_axis_tvalid[(int'(r_rr_ptr) + k) % N_PORTS]) begin
        w_req_found = 1'b1;
        w_pick      = GW'((int'(r_rr_ptr) + k) % N_PORTS);
      end else begin
        w_req_found = w_req_found;
      end
    end
  end

  // Next-state logic and the zero-latency stream pass-through.
  always_comb begin
    w_next_state  = r_state;
    s_axis_tready = {N_PORTS{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = w_sel_data;
    w_xfer        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_found) w_next_state = S_FWD;
        else             w_next_state = S_IDLE;
      end
      S_FWD: begin
        m_axis_tvalid             = w_sel_valid;
        m_axis_tlast              = w_sel_last | w_at_max;
        s_axis_tready[r_grant_id] = m_axis_tready;
        w_xfer                    = w_sel_valid & m_axis_tready;
        if (w_xfer && w_sel_last)    w_next_state = w_after_pkt;
        else if (w_xfer && w_at_max) w_next_state = S_DRAIN;
        else                         w_next_state = S_FWD;
      end
      S_DRAIN: begin
        s_axis_tready[r_grant_id] = 1'b1;
        if (w_sel_valid && w_sel_last) w_next_state = w_after_pkt;
        else                           w_next_state = S_DRAIN;
      end
      S_GAP: begin
        if (r_gap_cnt == GC_W'(GAP_CYCLES - 1)) w_next_state = S_IDLE;
        else                                     w_next_state = S_GAP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, grant bookkeeping, counters and registered status pulses.
  always_ff @(posedge Clk_user) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= {GW{1'b0}};
      r_grant_id <= {GW{1'b0}};
      r_word_cnt <= {WC_W{1'b0}};
      r_gap_cnt  <= {GC_W{1'b0}};
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state == S_FWD) || (w_next_state == S_DRAIN);
      r_pkt_done <= w_pkt_end;
      r_trunc    <= w_xfer & w_at_max & ~w_sel_last;
      if (r_state == S_IDLE && w_req_found) begin
        r_grant_id <= w_pick;
        r_word_cnt <= {WC_W{1'b0}};
      end else if (w_xfer) begin
        r_word_cnt <= r_word_cnt + {{(WC_W-1){1'b0}}, 1'b1};
      end else begin
        r_word_cnt <= r_word_cnt;
      end
      if (w_pkt_end) r_rr_ptr <= w_next_ptr;
      else           r_rr_ptr <= r_rr_ptr;
      // gap_cnt only runs while parked in GAP and restarts from zero each visit.
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + {{(GC_W-1){1'b0}}, 1'b1};
      else                  r_gap_cnt <= {GC_W{1'b0}};
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;
  assign trunc    = r_trunc;

endmodule
